// File: rtl/bus_alu.sv
`default_nettype none
// ============================================================================
//  Module   : bus_alu
//  Purpose  : RV32I ALU for a single shared tri-state bus. It holds a latched
//             right operand A and a registered result R. A compute cycle
//             evaluates R = bus OP A, and R is driven back onto the bus on
//             request.
//  Ports    : clk       - system clock, rising edge
//             rst_n     - asynchronous active-low reset
//             bus       - shared XLEN-bit bus; driven only while alu_rd=1
//             alu_wr    - sample the bus this cycle (load A or compute)
//             alu_rd    - drive R onto the bus (combinational)
//             alu_op    - bit4=0: load A; bit4=1: {1, alt, funct3} compute
//             alu_zero  - registered flag, last computed R == 0
//             alu_busy  - multi-cycle shift in progress
//  Options  : BUS_ALU_SERIAL_SHIFT_EN - replaces the barrel shifter with a
//             1-bit-per-cycle shifter (latency = shift amount, alu_busy
//             asserted while it runs). Undefined: single-cycle barrel
//             shifter, alu_busy tied to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module bus_alu #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  inout  wire [XLEN-1:0]  bus,
  input  logic            alu_wr,
  input  logic            alu_rd,
  input  logic [4:0]      alu_op,
  output logic            alu_zero,
  output logic            alu_busy
);

  logic [XLEN-1:0]    op_a;
  logic [XLEN-1:0]    res;
  logic [XLEN-1:0]    opnd;
  logic [XLEN-1:0]    f;
  logic [XLEN-1:0]    res_d;
  logic [2:0]         funct3;
  logic               alt;
  logic [SHAMT_W-1:0] shamt;
  logic               load_we;
  logic               res_we;

  assign funct3 = alu_op[2:0];
  assign alt    = alu_op[3];
  assign shamt  = op_a[SHAMT_W-1:0];

  assign bus = alu_rd ? res : {XLEN{1'bz}};

  // When we drive the bus ourselves, the sampled value is our own R. Taking
  // it from the register directly avoids resolving our own tri-state driver.
  assign opnd = alu_rd ? res : bus;

`ifndef BUS_ALU_SERIAL_SHIFT_EN
  // Kept as a separate signed net so the arithmetic shift is not demoted to
  // a logical one by unsigned operands elsewhere in the expression.
  logic signed [XLEN-1:0] sra_res;
  assign sra_res = $signed(opnd) >>> shamt;
`endif

  // Single-cycle function unit: f = opnd OP A
  always_comb begin
    f = '0;
    case (funct3)
      3'b000: f = alt ? (opnd - op_a) : (opnd + op_a);
`ifdef BUS_ALU_SERIAL_SHIFT_EN
      // Shifts go through the serial shifter; this path only covers the
      // zero-amount case, which returns the operand unchanged.
      3'b001: f = opnd;
      3'b101: f = opnd;
`else
      3'b001: f = opnd << shamt;
      3'b101: f = alt ? sra_res : (opnd >> shamt);
`endif
      3'b010: f = {{(XLEN-1){1'b0}}, ($signed(opnd) < $signed(op_a))};
      3'b011: f = {{(XLEN-1){1'b0}}, (opnd < op_a)};
      3'b100: f = opnd ^ op_a;
      3'b110: f = opnd | op_a;
      3'b111: f = opnd & op_a;
      default: f = '0;
    endcase
  end

`ifdef BUS_ALU_SERIAL_SHIFT_EN
  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } sh_state_t;

  sh_state_t          state;
  sh_state_t          state_nxt;
  logic [XLEN-1:0]    sh_reg;
  logic [XLEN-1:0]    sh_step;
  logic [SHAMT_W-1:0] cnt;
  logic               sh_left;
  logic               sh_arith;
  logic               is_shift;
  logic               cmp_ok;
  logic               sh_start;
  logic               sh_done;

  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
  // New requests are ignored entirely while a shift is running.
  assign cmp_ok   = alu_wr && alu_op[4] && (state == S_IDLE);
  assign sh_start = cmp_ok && is_shift && (shamt != '0);
  assign sh_done  = (state == S_SHIFT) && (cnt == SHAMT_W'(1));
  assign alu_busy = (state == S_SHIFT);

  assign load_we  = alu_wr && !alu_op[4] && (state == S_IDLE);
  assign res_we   = (cmp_ok && !sh_start) || sh_done;
  // The last shift step is written straight into R, so R becomes valid in
  // the same cycle alu_busy drops.
  assign res_d    = sh_done ? sh_step : f;

  always_comb begin
    sh_step = {1'b0, sh_reg[XLEN-1:1]};
    if (sh_left)
      sh_step = {sh_reg[XLEN-2:0], 1'b0};
    else if (sh_arith)
      sh_step = {sh_reg[XLEN-1], sh_reg[XLEN-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (sh_start) state_nxt = S_SHIFT;
      S_SHIFT: if (sh_done)  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_reg   <= '0;
      cnt      <= '0;
      sh_left  <= 1'b0;
      sh_arith <= 1'b0;
    end else if (sh_start) begin
      sh_reg   <= opnd;
      cnt      <= shamt;
      sh_left  <= ~funct3[2];
      sh_arith <= alt;
    end else if (state == S_SHIFT) begin
      sh_reg   <= sh_step;
      cnt      <= cnt - SHAMT_W'(1);
    end
  end
`else
  assign alu_busy = 1'b0;
  assign load_we  = alu_wr && !alu_op[4];
  assign res_we   = alu_wr && alu_op[4];
  assign res_d    = f;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a     <= '0;
      res      <= '0;
      alu_zero <= 1'b1;
    end else begin
      if (load_we)
        op_a <= opnd;
      if (res_we) begin
        res      <= res_d;
        alu_zero <= (res_d == '0);
      end
    end
  end

endmodule
`default_nettype wire
